// File: rtl/teste_sb_lock_rst_seq.sv
// ---------------------------------------------------------------------------
// teste_sb_lock_rst_seq
//
// Reset sequencer placed directly after the fabric CCC. It waits for the PLL
// LOCK to be stable for LOCK_STABLE_CYCLES clocks, releases the system reset
// domain, then releases the peripheral domain STAGE_GAP clocks later. Lock
// loss or a software request re-asserts both resets. Status (ready, sticky
// lock-lost, saturating loss counter) is exported for the command logic.
//
// Ports
//   CLK             in   fabric clock (CCC GL0)
//   RESET_N         in   asynchronous active-low reset
//   LOCK            in   CCC PLL lock, asynchronous to CLK
//   SW_RESET_REQ    in   single-cycle software reset request
//   CLR_STATUS      in   single-cycle clear of LOCK_LOST / LOSS_COUNT
//   SYS_RESET_N     out  active-low reset, system domain
//   PERIPH_RESET_N  out  active-low reset, peripheral domain
//   READY           out  both domains out of reset
//   LOCK_LOST       out  sticky lock-loss flag
//   LOSS_COUNT[7:0] out  saturating count of lock-loss events
// ---------------------------------------------------------------------------
module teste_sb_lock_rst_seq #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,  // 1..65535
  parameter int unsigned STAGE_GAP          = 16,    // 1..255
  parameter int unsigned SW_RST_CYCLES      = 8      // 1..255
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       LOCK,
  input  logic       SW_RESET_REQ,
  input  logic       CLR_STATUS,
  output logic       SYS_RESET_N,
  output logic       PERIPH_RESET_N,
  output logic       READY,
  output logic       LOCK_LOST,
  output logic [7:0] LOSS_COUNT
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    REL_SYS   = 2'd1,
    RUN       = 2'd2,
    SW_HOLD   = 2'd3
  } state_t;

  localparam logic [15:0] STAB_LAST = 16'(LOCK_STABLE_CYCLES - 1);
  localparam logic [7:0]  GAP_LAST  = 8'(STAGE_GAP - 1);
  localparam logic [7:0]  HOLD_LAST = 8'(SW_RST_CYCLES - 1);

  state_t      state_q, state_d;
  logic        sync1_q;
  logic        lock_s_q;
  logic [15:0] stab_cnt_q, stab_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic        sys_rst_n_q, periph_rst_n_q, ready_q;
  logic        lock_lost_q, lock_lost_d;
  logic [7:0]  loss_count_q, loss_count_d;
  logic        loss_event;

  // Next-state logic. Lock loss is checked before the software request so a
  // coincident pair is reported as a loss.
  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    hold_cnt_d = hold_cnt_q;
    loss_event = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (!lock_s_q) begin
          stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d    = REL_SYS;
          stab_cnt_d = '0;
          gap_cnt_d  = '0;
        end else begin
          stab_cnt_d = stab_cnt_q + 16'd1;
        end
      end
      REL_SYS, RUN: begin
        if (!lock_s_q) begin
          loss_event = 1'b1;
          state_d    = WAIT_LOCK;
          stab_cnt_d = '0;
        end else if (SW_RESET_REQ) begin
          state_d    = SW_HOLD;
          hold_cnt_d = HOLD_LAST;
        end else if (state_q == REL_SYS) begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d = RUN;
          end else begin
            gap_cnt_d = gap_cnt_q + 8'd1;
          end
        end
      end
      SW_HOLD: begin
        // Requests and lock changes are ignored here; resets are already low.
        if (hold_cnt_q == 8'd0) begin
          state_d    = WAIT_LOCK;
          stab_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Status: a loss event overrides a coincident clear, leaving count = 1.
  always_comb begin
    lock_lost_d  = lock_lost_q;
    loss_count_d = loss_count_q;
    if (CLR_STATUS) begin
      lock_lost_d  = 1'b0;
      loss_count_d = 8'd0;
    end
    if (loss_event) begin
      lock_lost_d  = 1'b1;
      if (CLR_STATUS) begin
        loss_count_d = 8'd1;
      end else if (loss_count_q != 8'hFF) begin
        loss_count_d = loss_count_q + 8'd1;
      end
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the transition.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q        <= 1'b0;
      lock_s_q       <= 1'b0;
      state_q        <= WAIT_LOCK;
      stab_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      hold_cnt_q     <= '0;
      sys_rst_n_q    <= 1'b0;
      periph_rst_n_q <= 1'b0;
      ready_q        <= 1'b0;
      lock_lost_q    <= 1'b0;
      loss_count_q   <= '0;
    end else begin
      sync1_q        <= LOCK;
      lock_s_q       <= sync1_q;
      state_q        <= state_d;
      stab_cnt_q     <= stab_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      sys_rst_n_q    <= (state_d == REL_SYS) || (state_d == RUN);
      periph_rst_n_q <= (state_d == RUN);
      ready_q        <= (state_d == RUN);
      lock_lost_q    <= lock_lost_d;
      loss_count_q   <= loss_count_d;
    end
  end

  assign SYS_RESET_N    = sys_rst_n_q;
  assign PERIPH_RESET_N = periph_rst_n_q;
  assign READY          = ready_q;
  assign LOCK_LOST      = lock_lost_q;
  assign LOSS_COUNT     = loss_count_q;

endmodule

// File: tb/tb_teste_sb_lock_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_teste_sb_lock_rst_seq
//
// Directed bench for the reset sequencer with LOCK_STABLE_CYCLES=8,
// STAGE_GAP=4, SW_RST_CYCLES=8. Inputs change and outputs are sampled 1 time
// unit after each rising edge; "edge N" counts rising edges after release.
// ---------------------------------------------------------------------------
module tb_teste_sb_lock_rst_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       lock;
  logic       sw_reset_req;
  logic       clr_status;
  logic       sys_reset_n;
  logic       periph_reset_n;
  logic       ready;
  logic       lock_lost;
  logic [7:0] loss_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  teste_sb_lock_rst_seq #(
    .LOCK_STABLE_CYCLES(8),
    .STAGE_GAP(4),
    .SW_RST_CYCLES(8)
  ) dut (
    .CLK(clk),
    .RESET_N(reset_n),
    .LOCK(lock),
    .SW_RESET_REQ(sw_reset_req),
    .CLR_STATUS(clr_status),
    .SYS_RESET_N(sys_reset_n),
    .PERIPH_RESET_N(periph_reset_n),
    .READY(ready),
    .LOCK_LOST(lock_lost),
    .LOSS_COUNT(loss_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_all_low(input string tag);
    chk({tag, "_sys"},    {15'd0, sys_reset_n},    16'd0);
    chk({tag, "_periph"}, {15'd0, periph_reset_n}, 16'd0);
    chk({tag, "_ready"},  {15'd0, ready},          16'd0);
  endtask

  // Bounded wait for SYS_RESET_N to reach a level; a timeout shows as a failed check.
  task automatic wait_sys(input logic val, input int budget, input string tag);
    int k;
    k = 0;
    while (sys_reset_n !== val && k < budget) begin
      step();
      k++;
    end
    chk(tag, {15'd0, sys_reset_n}, {15'd0, val});
  endtask

  initial begin
    reset_n      = 1'b0;
    lock         = 1'b1;
    sw_reset_req = 1'b0;
    clr_status   = 1'b0;
    repeat (2) step();

    // Reset values
    chk_all_low("rst");
    chk("rst_lock_lost", {15'd0, lock_lost}, 16'd0);
    chk("rst_loss_count", {8'd0, loss_count}, 16'd0);
    $display("phase reset: checks=%0d", n_checks);

    // Phase 1: LOCK already high at release -> SYS at edge 10, PERIPH at 14
    reset_n = 1'b1;
    repeat (9) step();
    chk("p1_sys_e9", {15'd0, sys_reset_n}, 16'd0);
    step();
    chk("p1_sys_e10", {15'd0, sys_reset_n}, 16'd1);
    chk("p1_periph_e10", {15'd0, periph_reset_n}, 16'd0);
    repeat (3) step();
    chk("p1_periph_e13", {15'd0, periph_reset_n}, 16'd0);
    step();
    chk("p1_periph_e14", {15'd0, periph_reset_n}, 16'd1);
    chk("p1_ready_e14", {15'd0, ready}, 16'd1);
    chk("p1_lock_lost", {15'd0, lock_lost}, 16'd0);
    $display("phase initial release: checks=%0d", n_checks);

    // Phase 2: 5 high, 1 captured low, then high -> release 10 edges after final rise
    reset_n = 1'b0;
    lock    = 1'b0;
    step();
    reset_n = 1'b1;
    lock    = 1'b1;
    repeat (5) step();
    lock = 1'b0;
    step();
    lock = 1'b1;
    repeat (9) step();
    chk("p2_sys_rise9", {15'd0, sys_reset_n}, 16'd0);
    step();
    chk("p2_sys_rise10", {15'd0, sys_reset_n}, 16'd1);
    chk("p2_lock_lost", {15'd0, lock_lost}, 16'd0);
    chk("p2_loss_count", {8'd0, loss_count}, 16'd0);
    repeat (4) step();
    chk("p2_ready", {15'd0, ready}, 16'd1);
    $display("phase glitch restart: checks=%0d", n_checks);

    // Phase 3: drop LOCK for 3 cycles in RUN
    lock = 1'b0;
    repeat (2) step();
    chk("p3_sys_fall2", {15'd0, sys_reset_n}, 16'd1);
    step();
    lock = 1'b1;
    chk_all_low("p3_fall3");
    chk("p3_lock_lost", {15'd0, lock_lost}, 16'd1);
    chk("p3_loss_count", {8'd0, loss_count}, 16'd1);
    repeat (9) step();
    chk("p3_relock_sys9", {15'd0, sys_reset_n}, 16'd0);
    step();
    chk("p3_relock_sys10", {15'd0, sys_reset_n}, 16'd1);
    repeat (4) step();
    chk("p3_relock_ready", {15'd0, ready}, 16'd1);
    $display("phase lock loss: checks=%0d", n_checks);

    // Phase 4: software reset in RUN; a second request mid-hold is ignored
    sw_reset_req = 1'b1;
    step();
    sw_reset_req = 1'b0;
    chk_all_low("p4_sw1");
    repeat (3) step();
    sw_reset_req = 1'b1;
    step();
    sw_reset_req = 1'b0;
    repeat (11) step();
    chk("p4_sys_e16", {15'd0, sys_reset_n}, 16'd0);
    step();
    chk("p4_sys_e17", {15'd0, sys_reset_n}, 16'd1);
    chk("p4_loss_count", {8'd0, loss_count}, 16'd1);
    repeat (3) step();
    chk("p4_periph_e20", {15'd0, periph_reset_n}, 16'd0);
    step();
    chk("p4_periph_e21", {15'd0, periph_reset_n}, 16'd1);
    chk("p4_ready_e21", {15'd0, ready}, 16'd1);
    $display("phase software reset: checks=%0d", n_checks);

    // Phase 5: clear, then 260 loss events -> saturation at 255
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    chk("p5_clr_lock_lost", {15'd0, lock_lost}, 16'd0);
    chk("p5_clr_loss_count", {8'd0, loss_count}, 16'd0);
    for (int i = 0; i < 260; i++) begin
      lock = 1'b1;
      wait_sys(1'b1, 40, "p5_loop_rise");
      lock = 1'b0;
      wait_sys(1'b0, 10, "p5_loop_fall");
      if (i == 253 || i == 259)
        chk("p5_loss_count_loop", {8'd0, loss_count},
            (i + 1 > 255) ? 16'd255 : 16'(i + 1));
    end
    chk("p5_sat_lock_lost", {15'd0, lock_lost}, 16'd1);
    $display("phase saturation: checks=%0d", n_checks);

    // Clear coinciding with a loss in REL_SYS -> loss wins, count = 1
    lock = 1'b1;
    wait_sys(1'b1, 40, "p5b_rise");
    lock = 1'b0;
    repeat (2) step();
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    chk("p5b_sys", {15'd0, sys_reset_n}, 16'd0);
    chk("p5b_lock_lost", {15'd0, lock_lost}, 16'd1);
    chk("p5b_loss_count", {8'd0, loss_count}, 16'd1);
    $display("phase clear vs loss: checks=%0d", n_checks);

    // Phase 6: async reset between SYS and PERIPH release
    lock = 1'b1;
    wait_sys(1'b1, 40, "p6_rise");
    repeat (2) step();
    reset_n = 1'b0;
    #1;
    chk_all_low("p6_async");
    chk("p6_async_lock_lost", {15'd0, lock_lost}, 16'd0);
    chk("p6_async_loss_count", {8'd0, loss_count}, 16'd0);
    step();
    reset_n = 1'b1;
    repeat (9) step();
    chk("p6_sys_e9", {15'd0, sys_reset_n}, 16'd0);
    step();
    chk("p6_sys_e10", {15'd0, sys_reset_n}, 16'd1);
    repeat (3) step();
    chk("p6_periph_e13", {15'd0, periph_reset_n}, 16'd0);
    step();
    chk("p6_periph_e14", {15'd0, periph_reset_n}, 16'd1);
    chk("p6_ready_e14", {15'd0, ready}, 16'd1);
    $display("phase async reset: checks=%0d", n_checks);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
